// File: rtl/win33_out_seq.sv
// Winograd F(2x2,3x3) output-transform sequencer.
// Sums per-tile M rows over channels, fires the transform, walks the tile map.
module win33_out_seq #(
  parameter int N_CH    = 6,
  parameter int TILES_X = 5,
  parameter int TILES_Y = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_row,
  output logic [63:0] m_tmp1,
  output logic [63:0] m_tmp2,
  output logic [63:0] m_tmp3,
  output logic [63:0] m_tmp4,
  output logic        xform_en,
  input  logic [31:0] f_tmp1,
  input  logic [31:0] f_tmp2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [7:0]  out_tx,
  output logic [7:0]  out_ty,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_XFORM,
    S_OUT
  } state_t;

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] CH_LAST = CW'(N_CH - 1);
  localparam logic [7:0] TX_LAST = 8'(TILES_X - 1);
  localparam logic [7:0] TY_LAST = 8'(TILES_Y - 1);

  state_t        state, state_nx;
  logic [63:0]   acc [4];
  logic [1:0]    row;
  logic [CW-1:0] ch;
  logic [7:0]    tx, ty;

  logic beat, last_beat, hs, last_tile, start_ok;

  assign beat      = in_valid & in_ready;
  assign last_beat = beat & (ch == CH_LAST) & (row == 2'd3);
  assign hs        = out_valid & out_ready;
  assign last_tile = (tx == TX_LAST) & (ty == TY_LAST);
  // start landing on the done pulse is dropped
  assign start_ok  = (state == S_IDLE) & start & ~done;

  assign m_tmp1 = acc[0];
  assign m_tmp2 = acc[1];
  assign m_tmp3 = acc[2];
  assign m_tmp4 = acc[3];

  function automatic logic [63:0] lane_add(
    input logic [63:0] a,
    input logic [63:0] b
  );
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      r[16*i +: 16] = a[16*i +: 16] + b[16*i +: 16];
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b1;
    in_ready  = 1'b0;
    xform_en  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start_ok) state_nx = S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (last_beat) state_nx = S_XFORM;
      end
      S_XFORM: begin
        xform_en = 1'b1;
        state_nx = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (hs) state_nx = last_tile ? S_IDLE : S_ACCUM;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      row      <= '0;
      ch       <= '0;
      tx       <= '0;
      ty       <= '0;
      out_data <= '0;
      out_tx   <= '0;
      out_ty   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_ok) begin
        tx  <= '0;
        ty  <= '0;
        ch  <= '0;
        row <= '0;
      end
      if (beat) begin
        acc[row] <= (ch == '0) ? in_row : lane_add(acc[row], in_row);
        row      <= row + 2'd1;
        if (row == 2'd3)
          ch <= (ch == CH_LAST) ? '0 : ch + CW'(1);
      end
      if (xform_en) begin
        out_data <= {f_tmp1, f_tmp2};
        out_tx   <= tx;
        out_ty   <= ty;
      end
      if (hs) begin
        ch  <= '0;
        row <= '0;
        if (last_tile) begin
          done <= 1'b1;
        end else if (tx == TX_LAST) begin
          tx <= '0;
          ty <= ty + 8'd1;
        end else begin
          tx <= tx + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_win33_out_seq.sv
// Bench for win33_out_seq: directed and random tiles against a matrix model.
// Two instances: N_CH=1 1x1 map and N_CH=2 2x2 map.
module tb_win33_out_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int beatn;
  int macc [4][4];

  // main instance: N_CH=2, 2x2 tiles
  logic        start, busy, in_valid, in_ready, xform_en;
  logic        out_valid, out_ready, done;
  logic [63:0] in_row, m1, m2, m3, m4, out_data;
  logic [31:0] f1, f2;
  logic [7:0]  out_tx, out_ty;

  // small instance: N_CH=1, 1x1 tiles
  logic        a_start, a_busy, a_in_valid, a_in_ready, a_xform_en;
  logic        a_out_valid, a_out_ready, a_done;
  logic [63:0] a_in_row, a_m1, a_m2, a_m3, a_m4, a_out_data;
  logic [31:0] a_f1, a_f2;
  logic [7:0]  a_out_tx, a_out_ty;

  // stand-in for the combinational win33_a transform
  function automatic logic [63:0] xf(
    input logic [63:0] r0, input logic [63:0] r1,
    input logic [63:0] r2, input logic [63:0] r3
  );
    logic [15:0] t0 [4];
    logic [15:0] t1 [4];
    for (int j = 0; j < 4; j++) begin
      t0[j] = r0[63-16*j -: 16] + r1[63-16*j -: 16] + r2[63-16*j -: 16];
      t1[j] = r1[63-16*j -: 16] - r2[63-16*j -: 16] - r3[63-16*j -: 16];
    end
    return {16'(t0[0] + t0[1] + t0[2]), 16'(t0[1] - t0[2] - t0[3]),
            16'(t1[0] + t1[1] + t1[2]), 16'(t1[1] - t1[2] - t1[3])};
  endfunction

  assign {f1, f2}     = xf(m1, m2, m3, m4);
  assign {a_f1, a_f2} = xf(a_m1, a_m2, a_m3, a_m4);

  win33_out_seq #(.N_CH(2), .TILES_X(2), .TILES_Y(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .m_tmp1(m1), .m_tmp2(m2), .m_tmp3(m3), .m_tmp4(m4),
    .xform_en(xform_en), .f_tmp1(f1), .f_tmp2(f2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tx(out_tx), .out_ty(out_ty), .done(done)
  );

  win33_out_seq #(.N_CH(1), .TILES_X(1), .TILES_Y(1)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_row(a_in_row),
    .m_tmp1(a_m1), .m_tmp2(a_m2), .m_tmp3(a_m3), .m_tmp4(a_m4),
    .xform_en(a_xform_en), .f_tmp1(a_f1), .f_tmp2(a_f2),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_tx(a_out_tx), .out_ty(a_out_ty),
    .done(a_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: Y = A^T * (sum of rows) * A, truncated to 16 bits at the end
  function automatic logic [63:0] ref_out();
    int at [2][4] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};
    int t [2][4];
    int y [2][2];
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++) begin
        t[i][j] = 0;
        for (int k = 0; k < 4; k++) t[i][j] += at[i][k] * macc[k][j];
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        y[i][j] = 0;
        for (int k = 0; k < 4; k++) y[i][j] += t[i][k] * at[j][k];
      end
    return {16'(y[0][0]), 16'(y[0][1]), 16'(y[1][0]), 16'(y[1][1])};
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) macc[r][c] = 0;
    beatn = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [63:0] r, input int gap);
    bit ok = 0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_row   = r;
    for (int w = 0; w < 20; w++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      for (int j = 0; j < 4; j++)
        macc[beatn % 4][j] += int'($signed(r[63-16*j -: 16]));
      beatn++;
    end
  endtask

  task automatic finish_tile(input logic [63:0] exp, input logic [7:0] etx,
                             input logic [7:0] ety, input bit last,
                             input int stall);
    logic [63:0] acc0;
    chk("xform_en", 64'(xform_en), 64'd1);
    chk("valid_early", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("out_data", out_data, exp);
    chk("out_tx", 64'(out_tx), 64'(etx));
    chk("out_ty", 64'(out_ty), 64'(ety));
    chk("xform_off", 64'(xform_en), 64'd0);
    acc0 = m1 ^ m2 ^ m3 ^ m4;
    for (int s = 0; s < stall; s++) begin
      in_valid = ~in_valid;
      in_row   = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", out_data, exp);
      chk("hold_txy", {48'd0, out_ty, out_tx}, {48'd0, ety, etx});
      chk("hold_acc", m1 ^ m2 ^ m3 ^ m4, acc0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("done", 64'(done), 64'(last));
    chk("busy_after", 64'(busy), 64'(!last));
    chk("valid_drop", 64'(out_valid), 64'd0);
    chk("data_kept", out_data, exp);
  endtask

  initial begin
    rst = 1'b1;
    start = 0; in_valid = 0; in_row = '0; out_ready = 0;
    a_start = 0; a_in_valid = 0; a_in_row = '0; a_out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_xform", 64'(xform_en), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_txy", {48'd0, out_ty, out_tx}, 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_m", m1 | m2 | m3 | m4, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // N_CH=1, 1x1: four all-ones rows
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start    = 1'b0;
    a_in_valid = 1'b1;
    a_in_row   = 64'h0001_0001_0001_0001;
    for (int b = 0; b < 4; b++) begin
      chk("a_in_ready", 64'(a_in_ready), 64'd1);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    chk("a_xform", 64'(a_xform_en), 64'd1);
    @(posedge clk); #1;
    chk("a_valid", 64'(a_out_valid), 64'd1);
    chk("a_data", a_out_data, 64'h0009_FFFD_FFFD_0001);
    chk("a_txy", {48'd0, a_out_ty, a_out_tx}, 64'd0);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    chk("a_done", 64'(a_done), 64'd1);
    chk("a_busy", 64'(a_busy), 64'd0);
    @(posedge clk); #1;
    chk("a_done_pulse", 64'(a_done), 64'd0);

    // tile (0,0): all-ones rows twice, then backpressure
    pulse_start();
    clear_model();
    for (int b = 0; b < 8; b++) send(64'h0001_0001_0001_0001, 0);
    finish_tile(64'h0012_FFFA_FFFA_0002, 8'd0, 8'd0, 0, 5);

    // tile (1,0): lane wrap
    clear_model();
    send(64'h7FFF_0000_0000_0000, 0);
    for (int b = 0; b < 3; b++) send(64'd0, 0);
    send(64'h0001_0000_0000_0000, 0);
    for (int b = 0; b < 3; b++) send(64'd0, 0);
    chk("wrap_m", 64'(m1[63:48]), 64'h8000);
    finish_tile(64'h8000_0000_0000_0000, 8'd1, 8'd0, 0, 0);

    // tile (0,1): random rows and gaps, stray start while busy
    pulse_start();
    clear_model();
    for (int b = 0; b < 8; b++)
      send({$urandom, $urandom}, int'($urandom_range(0, 2)));
    finish_tile(ref_out(), 8'd0, 8'd1, 0, 0);

    // tile (1,1): last tile
    clear_model();
    for (int b = 0; b < 8; b++)
      send({$urandom, $urandom}, int'($urandom_range(0, 2)));
    finish_tile(ref_out(), 8'd1, 8'd1, 1, 1);

    // start coincident with done is dropped
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_on_done", 64'(busy), 64'd0);
    chk("done_pulse", 64'(done), 64'd0);
    pulse_start();
    chk("restart", 64'(busy), 64'd1);

    // reset in the middle of a tile
    clear_model();
    for (int b = 0; b < 3; b++) send({$urandom, $urandom}, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_m", m1 | m2 | m3 | m4, 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    pulse_start();
    for (int b = 0; b < 8; b++)
      send({$urandom, $urandom}, int'($urandom_range(0, 1)));
    finish_tile(ref_out(), 8'd0, 8'd0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
